id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus stall/flush sequencer for the 5-stage miniRV pipeline.
//  - Latches decoded controls and forwarded operands (new_rD1/new_rD2 from data_hazard_detection) into EX.
//  - Turns load-use hazards into PC/IF-ID hold + EX bubble; turns EX-resolved jumps/branches into IF/ID + ID/EX flush.

---
 rtl/id_ex_stage_pkg.sv | 17 +
 rtl/id_ex_stage_pipe_reg.sv | 21 ++
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the miniRV ID/EX stage: write-back selects, next-pc ops and sequencer states.
package id_ex_stage_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_DRAM = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_EXT  = 2'b11;

  // Bubbles clear the control bundle to zero, so pc+4 must stay the all-zero encoding.
  localparam logic [1:0] NPC_PC4 = 2'b00;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/id_ex_stage_pipe_reg.sv
// Generic pipeline register: synchronous active-low reset, clear (bubble) beats load.
module id_ex_stage_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: reset is sampled inside the clocked block (synchronous), and all state uses <= so
  // every register sees pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n)     q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and EX-redirect flush sequencing for miniRV.
// Optional build macro PERF_CNT_EN adds stall/flush performance counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int ALU_OP_W  = 4,
  parameter int NPC_OP_W  = 2,
  parameter int MAX_STALL = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ID_valid,
  input  logic [DATA_W-1:0]   ID_pc4,
  input  logic [DATA_W-1:0]   ID_ext,
  input  logic [DATA_W-1:0]   ID_rD1,
  input  logic [DATA_W-1:0]   ID_rD2,
  input  logic [REG_AW-1:0]   ID_wR,
  input  logic                ID_rf_we,
  input  logic [1:0]          ID_rf_wsel,
  input  logic [ALU_OP_W-1:0] ID_alu_op,
  input  logic                ID_alub_sel,
  input  logic                ID_ram_we,
  input  logic [NPC_OP_W-1:0] ID_npc_op,
  input  logic                data_hazard,
  input  logic                EX_redirect,
  output logic                EX_valid,
  output logic [DATA_W-1:0]   EX_pc4,
  output logic [DATA_W-1:0]   EX_ext,
  output logic [DATA_W-1:0]   EX_rD1,
  output logic [DATA_W-1:0]   EX_rD2,
  output logic [REG_AW-1:0]   EX_wR,
  output logic                EX_rf_we,
  output logic [1:0]          EX_rf_wsel,
  output logic [ALU_OP_W-1:0] EX_alu_op,
  output logic                EX_alub_sel,
  output logic                EX_ram_we,
  output logic [NPC_OP_W-1:0] EX_npc_op,
  output logic                pc_stall,
  output logic                ifid_stall,
  output logic                ifid_flush,
`ifdef PERF_CNT_EN
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt,
`endif
  output logic                stall_err
);

  localparam int DBUS_W = 4 * DATA_W;
  localparam int CBUS_W = 1 + REG_AW + 1 + 2 + ALU_OP_W + 1 + 1 + NPC_OP_W;
  localparam int CNT_W  = $clog2(MAX_STALL + 2);
  localparam logic [CNT_W-1:0] RUN_SAT   = CNT_W'(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_STALL);

  logic             stall_cycle;
  logic             bubble;
  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_nxt;

  // A redirect squashes the hazarding instruction, so it suppresses the stall.
  assign stall_cycle = data_hazard & ~EX_redirect;
  assign bubble      = EX_redirect | data_hazard;
  assign pc_stall    = stall_cycle;
  assign ifid_stall  = stall_cycle;
  assign ifid_flush  = EX_redirect;

  id_ex_stage_pipe_reg #(.W(DBUS_W)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .clear (bubble),
    .d     ({ID_pc4, ID_ext, ID_rD1, ID_rD2}),
    .q     ({EX_pc4, EX_ext, EX_rD1, EX_rD2})
  );

  id_ex_stage_pipe_reg #(.W(CBUS_W)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .clear (bubble),
    .d     ({ID_valid, ID_wR, ID_rf_we, ID_rf_wsel, ID_alu_op, ID_alub_sel, ID_ram_we, ID_npc_op}),
    .q     ({EX_valid, EX_wR, EX_rf_we, EX_rf_wsel, EX_alu_op, EX_alub_sel, EX_ram_we, EX_npc_op})
  );

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    run_nxt = '0;
    if (stall_cycle) begin
      if (state == ST_RUN)         run_nxt = CNT_W'(1);
      else if (run_cnt == RUN_SAT) run_nxt = run_cnt;
      else                         run_nxt = run_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      run_cnt   <= '0;
      stall_err <= 1'b0;
    end else begin
      case (state)
        ST_RUN:   state <= stall_cycle ? ST_STALL : ST_RUN;
        ST_STALL: state <= stall_cycle ? ST_STALL : ST_RUN;
        default:  state <= ST_RUN;
      endcase
      run_cnt <= run_nxt;
      // A legal load-use costs one stall cycle; a run past the limit is a sticky fault.
      if (run_nxt > RUN_LIMIT) stall_err <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_cycle) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (EX_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized traffic against a
// behavioural model of the stage (copy-or-bubble, stall run length, sticky error, counters).
module tb_id_ex_stage;

  localparam int MAX_STALL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ID_valid = 1'b0;
  logic [31:0] ID_pc4 = '0, ID_ext = '0, ID_rD1 = '0, ID_rD2 = '0;
  logic [4:0]  ID_wR = '0;
  logic        ID_rf_we = 1'b0;
  logic [1:0]  ID_rf_wsel = '0;
  logic [3:0]  ID_alu_op = '0;
  logic        ID_alub_sel = 1'b0, ID_ram_we = 1'b0;
  logic [1:0]  ID_npc_op = '0;
  logic        data_hazard = 1'b0, EX_redirect = 1'b0;

  logic        EX_valid;
  logic [31:0] EX_pc4, EX_ext, EX_rD1, EX_rD2;
  logic [4:0]  EX_wR;
  logic        EX_rf_we;
  logic [1:0]  EX_rf_wsel;
  logic [3:0]  EX_alu_op;
  logic        EX_alub_sel, EX_ram_we;
  logic [1:0]  EX_npc_op;
  logic        pc_stall, ifid_stall, ifid_flush, stall_err;
`ifdef PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_pc4(ID_pc4), .ID_ext(ID_ext), .ID_rD1(ID_rD1), .ID_rD2(ID_rD2),
    .ID_wR(ID_wR), .ID_rf_we(ID_rf_we), .ID_rf_wsel(ID_rf_wsel), .ID_alu_op(ID_alu_op),
    .ID_alub_sel(ID_alub_sel), .ID_ram_we(ID_ram_we), .ID_npc_op(ID_npc_op),
    .data_hazard(data_hazard), .EX_redirect(EX_redirect),
    .EX_valid(EX_valid), .EX_pc4(EX_pc4), .EX_ext(EX_ext), .EX_rD1(EX_rD1), .EX_rD2(EX_rD2),
    .EX_wR(EX_wR), .EX_rf_we(EX_rf_we), .EX_rf_wsel(EX_rf_wsel), .EX_alu_op(EX_alu_op),
    .EX_alub_sel(EX_alub_sel), .EX_ram_we(EX_ram_we), .EX_npc_op(EX_npc_op),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
`ifdef PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4, ext, rd1, rd2;
    logic [4:0]  wr;
    logic        rf_we;
    logic [1:0]  wsel;
    logic [3:0]  alu_op;
    logic        alub_sel, ram_we;
    logic [1:0]  npc_op;
  } ex_t;

  ex_t         exp_ex;
  int          run_len;
  logic        exp_err;
  logic [31:0] exp_ps, exp_pf;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic rand_id();
    ID_valid    = 1'($urandom);
    ID_pc4      = $urandom;
    ID_ext      = $urandom;
    ID_rD1      = $urandom;
    ID_rD2      = $urandom;
    ID_wR       = 5'($urandom);
    ID_rf_we    = 1'($urandom);
    ID_rf_wsel  = 2'($urandom);
    ID_alu_op   = 4'($urandom);
    ID_alub_sel = 1'($urandom);
    ID_ram_we   = 1'($urandom);
    ID_npc_op   = 2'($urandom);
  endtask

  // One clock: check same-cycle outputs, advance the model, then check registered outputs.
  task automatic step(input string tag);
    logic stall_c;
    #1;
    stall_c = data_hazard && !EX_redirect;
    chk({tag, ".pc_stall"},   32'(pc_stall),   32'(stall_c));
    chk({tag, ".ifid_stall"}, 32'(ifid_stall), 32'(stall_c));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(EX_redirect));
    if (!rst_n) begin
      exp_ex = '0; run_len = 0; exp_err = 1'b0; exp_ps = '0; exp_pf = '0;
    end else begin
      if (EX_redirect || data_hazard) exp_ex = '0;
      else begin
        exp_ex.valid = ID_valid;   exp_ex.pc4 = ID_pc4;       exp_ex.ext = ID_ext;
        exp_ex.rd1 = ID_rD1;       exp_ex.rd2 = ID_rD2;       exp_ex.wr = ID_wR;
        exp_ex.rf_we = ID_rf_we;   exp_ex.wsel = ID_rf_wsel;  exp_ex.alu_op = ID_alu_op;
        exp_ex.alub_sel = ID_alub_sel; exp_ex.ram_we = ID_ram_we; exp_ex.npc_op = ID_npc_op;
      end
      run_len = stall_c ? run_len + 1 : 0;
      if (run_len > MAX_STALL) exp_err = 1'b1;
      if (stall_c) exp_ps++;
      if (EX_redirect) exp_pf++;
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"},    32'(EX_valid),    32'(exp_ex.valid));
    chk({tag, ".pc4"},      EX_pc4,           exp_ex.pc4);
    chk({tag, ".ext"},      EX_ext,           exp_ex.ext);
    chk({tag, ".rD1"},      EX_rD1,           exp_ex.rd1);
    chk({tag, ".rD2"},      EX_rD2,           exp_ex.rd2);
    chk({tag, ".wR"},       32'(EX_wR),       32'(exp_ex.wr));
    chk({tag, ".rf_we"},    32'(EX_rf_we),    32'(exp_ex.rf_we));
    chk({tag, ".rf_wsel"},  32'(EX_rf_wsel),  32'(exp_ex.wsel));
    chk({tag, ".alu_op"},   32'(EX_alu_op),   32'(exp_ex.alu_op));
    chk({tag, ".alub_sel"}, 32'(EX_alub_sel), 32'(exp_ex.alub_sel));
    chk({tag, ".ram_we"},   32'(EX_ram_we),   32'(exp_ex.ram_we));
    chk({tag, ".npc_op"},   32'(EX_npc_op),   32'(exp_ex.npc_op));
    chk({tag, ".stall_err"}, 32'(stall_err),  32'(exp_err));
`ifdef PERF_CNT_EN
    chk({tag, ".perf_stall"}, perf_stall_cnt, exp_ps);
    chk({tag, ".perf_flush"}, perf_flush_cnt, exp_pf);
`endif
  endtask

  initial begin
    exp_ex = '0; run_len = 0; exp_err = 1'b0; exp_ps = '0; exp_pf = '0;

    // 1: reset with busy ID inputs
    @(posedge clk); #1;
    rand_id(); ID_valid = 1'b1; ID_rf_we = 1'b1; ID_rD1 = 32'hdead_beef; ID_rf_wsel = 2'b11;
    rst_n = 1'b0;
    step("t1.rst_a");
    step("t1.rst_b");
    chk("t1.valid_lit", 32'(EX_valid), 32'd0);
    chk("t1.rD1_lit", EX_rD1, 32'd0);

    // 2: add x3 with forwarded operands 5 and 7
    rst_n = 1'b1;
    rand_id();
    ID_valid = 1'b1; ID_rD1 = 32'd5; ID_rD2 = 32'd7; ID_wR = 5'd3; ID_rf_we = 1'b1;
    ID_rf_wsel = 2'b00; ID_ram_we = 1'b0; ID_npc_op = 2'b00;
    step("t2.add");
    chk("t2.rD1_lit", EX_rD1, 32'd5);
    chk("t2.rD2_lit", EX_rD2, 32'd7);
    chk("t2.wR_lit", 32'(EX_wR), 32'd3);
    chk("t2.valid_lit", 32'(EX_valid), 32'd1);

    // 3: single load-use stall then the held instruction passes
    data_hazard = 1'b1;
    step("t3.stall");
    chk("t3.valid_lit", 32'(EX_valid), 32'd0);
    chk("t3.rf_we_lit", 32'(EX_rf_we), 32'd0);
    data_hazard = 1'b0;
    step("t3.pass");
    chk("t3.pass_valid_lit", 32'(EX_valid), 32'd1);
    chk("t3.err_lit", 32'(stall_err), 32'd0);

    // 4: redirect wins over hazard
    data_hazard = 1'b1; EX_redirect = 1'b1;
    #1;
    chk("t4.flush_lit", 32'(ifid_flush), 32'd1);
    chk("t4.pc_stall_lit", 32'(pc_stall), 32'd0);
    step("t4.redirect");
    chk("t4.valid_lit", 32'(EX_valid), 32'd0);
    EX_redirect = 1'b0; data_hazard = 1'b0;
    step("t4.after");

    // reset asserted in the middle of a stall run
    data_hazard = 1'b1;
    step("tr.stall1");
    step("tr.stall2");
    rst_n = 1'b0;
    step("tr.rst");
    rst_n = 1'b1;
    step("tr.stall_after_rst");
    data_hazard = 1'b0;
    step("tr.release");
    chk("tr.err_lit", 32'(stall_err), 32'd0);

    // 5: hazard held past the limit sets the sticky error
    data_hazard = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("t5.stall%0d", i));
      chk($sformatf("t5.err_lit%0d", i), 32'(stall_err), (i == 4) ? 32'd1 : 32'd0);
    end
    data_hazard = 1'b0;
    step("t5.drop");
    step("t5.hold");
    chk("t5.sticky_lit", 32'(stall_err), 32'd1);

    // 6: counters (checked against the model every step when enabled)
    rst_n = 1'b0;
    step("t6.rst");
    rst_n = 1'b1;
    data_hazard = 1'b1;
    step("t6.s1");
    step("t6.s2");
    data_hazard = 1'b0; EX_redirect = 1'b1;
    step("t6.r1");
    EX_redirect = 1'b0;
    step("t6.idle");
`ifdef PERF_CNT_EN
    chk("t6.stall_lit", perf_stall_cnt, 32'd2);
    chk("t6.flush_lit", perf_flush_cnt, 32'd1);
    rst_n = 1'b0;
    step("t6.rst2");
    chk("t6.stall_clr", perf_stall_cnt, 32'd0);
    chk("t6.flush_clr", perf_flush_cnt, 32'd0);
    rst_n = 1'b1;
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rst_n       = ($urandom_range(0, 59) != 0);
      data_hazard = ($urandom_range(0, 2) == 0);
      EX_redirect = ($urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
